dram_bit_gatherer: RTL and testbench

//   Reader side of the 1-bit distributed-RAM double-buffer scheme. On request it sweeps
//   one section of a single-bit-wide LUT RAM (RAM32X1S/RAM64X1S), one address per cycle.
//   It reassembles IO_WIDTH bits into a parallel word and presents that word on a

---
 rtl/dram_gather_pkg.sv | 19 +
 rtl/dram_gather_ctr.sv | 26 ++
 rtl/dram_bit_gatherer.sv | 121 ++++++++++++
 tb/tb_dram_bit_gatherer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/dram_gather_pkg.sv
// Shared types and defaults for the distributed-RAM bit gatherer.
package dram_gather_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } gather_state_t;

  localparam int DEF_IO_WIDTH     = 16;
  localparam int DEF_ADDR_WIDTH   = 5;
  localparam int DEF_SECTION_BITS = 1;

  // Number of RAM addresses visited per sweep: data bits plus optional parity bit.
  function automatic int calc_sweep_len(input int io_width, input bit parity);
    return io_width + (parity ? 1 : 0);
  endfunction

endpackage

// File: rtl/dram_gather_ctr.sv
// Bit-index counter for the gather sweep: load to zero, count up, stick at LAST.
module dram_gather_ctr #(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] LAST  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] idx,
  output logic             tc
);

  assign tc = (idx == LAST);

  // Counter saturates at LAST so the index can never wrap past the section.
  always_ff @(posedge clk) begin
    if (rst)
      idx <= '0;
    else if (load)
      idx <= '0;
    else if (en && !tc)
      idx <= idx + WIDTH'(1);
  end

endmodule

// File: rtl/dram_bit_gatherer.sv
// Reader side of the 1-bit distributed-RAM double buffer: sweeps one section of
// the LUT RAM one address per cycle and presents the reassembled word.
// Optional feature macro: DRAM_GATHER_PARITY_EN (extra even-parity sample and
// parity_err output).
module dram_bit_gatherer
  import dram_gather_pkg::*;
#(
  parameter int IO_WIDTH     = DEF_IO_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int SECTION_BITS = DEF_SECTION_BITS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [SECTION_BITS-1:0]        req_sect,
  output logic [SECTION_BITS+ADDR_WIDTH-1:0] ram_addr,
  input  logic                           ram_out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [IO_WIDTH-1:0]            out_data,
  output logic                           busy
`ifdef DRAM_GATHER_PARITY_EN
  ,
  output logic                           parity_err
`endif
);

`ifdef DRAM_GATHER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int                    SWEEP_LEN = calc_sweep_len(IO_WIDTH, PAR_EN);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(SWEEP_LEN - 1);

  gather_state_t            state;
  logic [SECTION_BITS-1:0]  sect;
  logic [ADDR_WIDTH-1:0]    idx;
  logic                     tc;
  logic                     smp_en;   // ram_addr holds a valid sweep address this cycle
  logic [ADDR_WIDTH-1:0]    smp_idx;

  assign req_ready = (state == IDLE);
  assign smp_idx   = ram_addr[ADDR_WIDTH-1:0];

  dram_gather_ctr #(
    .WIDTH (ADDR_WIDTH),
    .LAST  (LAST_IDX)
  ) u_ctr (
    .clk  (clk),
    .rst  (rst),
    .load (state == IDLE && req_valid),
    .en   (state == READ),
    .idx  (idx),
    .tc   (tc)
  );

  // Sweep FSM: ram_addr is a registered copy of {sect, idx}, so the RAM output
  // for an address is sampled one edge after that address is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sect       <= '0;
      ram_addr   <= '0;
      smp_en     <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
`ifdef DRAM_GATHER_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            sect     <= req_sect;
            out_data <= '0;
            smp_en   <= 1'b0;
            busy     <= 1'b1;
            state    <= READ;
`ifdef DRAM_GATHER_PARITY_EN
            parity_err <= 1'b0;
`endif
          end
        end
        READ: begin
          ram_addr <= {sect, idx};
          smp_en   <= 1'b1;
          if (smp_en) begin
            for (int i = 0; i < IO_WIDTH; i++)
              if (smp_idx == ADDR_WIDTH'(i)) out_data[i] <= ram_out;
`ifdef DRAM_GATHER_PARITY_EN
            // Data bits are all captured by the time the parity address is sampled.
            if (smp_idx == ADDR_WIDTH'(IO_WIDTH))
              parity_err <= ^{out_data, ram_out};
`endif
            if (smp_idx == LAST_IDX) begin
              out_valid <= 1'b1;
              smp_en    <= 1'b0;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // tc is informational for the sweep; the FSM terminates on the sampled address.
  logic unused_tc;
  assign unused_tc = tc;

endmodule

// File: tb/tb_dram_bit_gatherer.sv
// Directed, table-driven bench for dram_bit_gatherer with a behavioural 64x1 RAM.
module tb_dram_bit_gatherer;

`ifdef DRAM_GATHER_PARITY_EN
  localparam int SWEEP = 17;
`else
  localparam int SWEEP = 16;
`endif
  localparam int LAT = SWEEP + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [0:0]  req_sect = 1'b0;
  logic [5:0]  ram_addr;
  logic        ram_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        busy;
`ifdef DRAM_GATHER_PARITY_EN
  logic        parity_err;
`endif

  logic [63:0] ram = '0;
  assign ram_out = ram[ram_addr];

  always #5 clk = ~clk;

  dram_bit_gatherer dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sect  (req_sect),
    .ram_addr  (ram_addr),
    .ram_out   (ram_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef DRAM_GATHER_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] init;
    logic        sect;
    logic [15:0] exp_data;
    logic        exp_perr;
  } vec_t;

  // Issue a request, then follow the sweep to HOLD checking the address walk and latency.
  task automatic run_sweep(input logic s);
    bit walk_ok = 1'b1;
    bit lat_ok  = 1'b1;
    req_sect  = s;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_sect  = ~s;  // must be ignored after acceptance
    chk("accept_ready_busy", {62'd0, req_ready, busy}, 64'b01);
    for (int c = 1; c <= LAT; c++) begin
      @(posedge clk); #1;
      if (c <= SWEEP && ram_addr !== {s, 5'(c - 1)}) walk_ok = 1'b0;
      if (out_valid !== (c == LAT)) lat_ok = 1'b0;
    end
    chk("addr_walk", {63'd0, walk_ok}, 64'd1);
    chk("latency", {63'd0, lat_ok}, 64'd1);
  endtask

  task automatic finish_hs();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_idle", {61'd0, out_valid, req_ready, busy}, 64'b010);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{64'h0000_96A5_0000_96A5, 1'b0, 16'h96A5, 1'b0};
    vecs[1] = '{64'h0000_5A3C_FFFF_1234, 1'b1, 16'h5A3C, 1'b0};
    vecs[2] = '{64'hFFFF_0000_FFFF_0000, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{64'h1234_FFFF_0000_8001, 1'b1, 16'hFFFF, 1'b0};
    vecs[4] = '{64'h1234_FFFF_0000_8001, 1'b0, 16'h8001, 1'b0};
    vecs[5] = '{64'h0000_0000_0000_0001, 1'b0, 16'h0001, 1'b1};
    vecs[6] = '{64'h0000_0000_0001_0001, 1'b0, 16'h0001, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_flags", {61'd0, out_valid, req_ready, busy}, 64'b010);
    chk("rst_data", {48'd0, out_data}, 64'd0);
    chk("rst_addr", {58'd0, ram_addr}, 64'd0);
`ifdef DRAM_GATHER_PARITY_EN
    chk("rst_perr", {63'd0, parity_err}, 64'd0);
`endif

    // Table-driven sweeps
    for (int i = 0; i < 7; i++) begin
      ram = vecs[i].init;
      run_sweep(vecs[i].sect);
      chk($sformatf("data_%0d", i), {48'd0, out_data}, {48'd0, vecs[i].exp_data});
`ifdef DRAM_GATHER_PARITY_EN
      chk($sformatf("perr_%0d", i), {63'd0, parity_err}, {63'd0, vecs[i].exp_perr});
`endif
      if (i == 0) begin
        // Back-pressure: word must hold steady while out_ready is low.
        bit hold_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
          @(posedge clk); #1;
          if (out_valid !== 1'b1 || out_data !== 16'h96A5 || req_ready !== 1'b0) hold_ok = 1'b0;
        end
        chk("hold_stable", {63'd0, hold_ok}, 64'd1);
      end
      finish_hs();
    end

    // Reset in the middle of READ discards the partial word.
    ram = 64'h0000_5A3C_0000_96A5;
    req_sect = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_flags", {61'd0, out_valid, req_ready, busy}, 64'b010);
    chk("midrst_data", {48'd0, out_data}, 64'd0);
    chk("midrst_addr", {58'd0, ram_addr}, 64'd0);
    run_sweep(1'b1);
    chk("post_rst_data", {48'd0, out_data}, 64'h5A3C);
    finish_hs();

    // Writer flips bit 3 around its sample edge; only the value at that edge counts.
    begin
      bit lat_ok = 1'b1;
      ram = 64'h0;
      req_sect = 1'b0; req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      for (int c = 1; c <= LAT; c++) begin
        @(posedge clk); #1;
        if (c == 2) ram[3] = 1'b1;   // lands before address 3 is sampled
        if (c == 5) ram[3] = 1'b0;   // after the sample edge for address 3
        if (out_valid !== (c == LAT)) lat_ok = 1'b0;
      end
      chk("toggle_latency", {63'd0, lat_ok}, 64'd1);
      chk("toggle_data", {48'd0, out_data}, 64'h0008);
      finish_hs();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
